// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and selectable registered or first-word-fall-through read.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 2**ADDR_W - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**ADDR_W;

    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_param: AE_LEVEL out of range");
    end
    if (ADDR_W < 1 || DATA_W < 1) begin : g_bad_w
        $error("sync_fifo_param: ADDR_W and DATA_W must be at least 1");
    end

    localparam logic [ADDR_W:0] AF_L = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_L = AE_LEVEL[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0] wrptr_q, wrptr_d;
    logic [ADDR_W:0] rdptr_q, rdptr_d;
    logic            overflow_q, underflow_q;
    logic            rd_ok, wr_ok;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wrptr_q == rdptr_q);
    assign full  = (wrptr_q[ADDR_W] != rdptr_q[ADDR_W]) &&
                   (wrptr_q[ADDR_W-1:0] == rdptr_q[ADDR_W-1:0]);
    assign count        = wrptr_q - rdptr_q;
    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    assign rd_ok = re && !empty;
    assign wr_ok = we && (!full || rd_ok);

    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        if (wr_ok) wrptr_d = wrptr_q + {{ADDR_W{1'b0}}, 1'b1};
        if (rd_ok) rdptr_d = rdptr_q + {{ADDR_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrptr_q     <= '0;
            rdptr_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrptr_q     <= wrptr_d;
            rdptr_q     <= rdptr_d;
            overflow_q  <= we && !wr_ok;
            underflow_q <= re && !rd_ok;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wrptr_q[ADDR_W-1:0]] <= din;
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              dout_valid_q, dout_valid_d;

        always_comb begin
            dout_d       = dout_q;
            dout_valid_d = rd_ok;
            if (rd_ok) dout_d = mem[rdptr_q[ADDR_W-1:0]];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_q       <= dout_d;
                dout_valid_q <= dout_valid_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end else begin : g_fwft_read
        // Head word is presented directly; forced to zero so an empty FIFO never shows stale data.
        assign dout       = empty ? '0 : mem[rdptr_q[ADDR_W-1:0]];
        assign dout_valid = !empty;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: registered-read instance checked against a queue model,
// plus a first-word-fall-through instance exercised directly.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0, re = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] dout;
    logic       dout_valid, empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] count;

    logic       we1 = 1'b0, re1 = 1'b0;
    logic [7:0] din1 = '0;
    logic [7:0] dout1;
    logic       dout_valid1, empty1, full1, almost_empty1, almost_full1, overflow1, underflow1;
    logic [4:0] count1;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] model[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .we(we), .din(din), .re(re),
        .dout(dout), .dout_valid(dout_valid), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .we(we1), .din(din1), .re(re1),
        .dout(dout1), .dout_valid(dout_valid1), .empty(empty1), .full(full1),
        .almost_empty(almost_empty1), .almost_full(almost_full1), .count(count1),
        .overflow(overflow1), .underflow(underflow1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_status(input bit exp_ovf, input bit exp_udf);
        int n;
        n = model.size();
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == 16));
        chk("almost_full", 32'(almost_full), 32'(n >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("underflow", 32'(underflow), 32'(exp_udf));
    endtask

    // One clock of stimulus on the registered-read FIFO; expected reads go to the scoreboard.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        bit rd_ok, wr_ok;
        rd_ok = r && (model.size() > 0);
        wr_ok = w && ((model.size() < 16) || rd_ok);
        if (rd_ok) exp_q.push_back(model.pop_front());
        if (wr_ok) model.push_back(d);
        we = w; din = d; re = r;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
        chk_status(w && !wr_ok, r && !rd_ok);
    endtask

    // Monitor: every dout_valid pulse must match the next expected word.
    always @(negedge clk) begin
        if (rst && dout_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_dout_valid", 32'(dout_valid), 32'd0);
            end else begin
                chk("dout", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] last;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk_status(1'b0, 1'b0);

        // Fill to full, then one rejected write.
        for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'h11, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);

        // Simultaneous write and read while full.
        cyc(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("drain_done", 32'(exp_q.size()), 32'd0);

        // Interleaved single writes and reads, pointers wrap several times.
        last = 8'h00;
        for (int i = 0; i < 40; i++) begin
            last = 8'(8'h40 + i);
            cyc(1'b1, last, 1'b0);
            cyc(1'b0, 8'h00, 1'b1);
        end
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("udf_dout_hold", 32'(dout), 32'(last));
        chk("udf_dout_valid", 32'(dout_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);

        // First-word-fall-through instance.
        chk("fwft_empty_dout", 32'(dout1), 32'd0);
        chk("fwft_empty_valid", 32'(dout_valid1), 32'd0);
        we1 = 1'b1; din1 = 8'h5C;
        @(posedge clk); #1;
        we1 = 1'b0;
        chk("fwft_dout", 32'(dout1), 32'h5C);
        chk("fwft_valid", 32'(dout_valid1), 32'd1);
        chk("fwft_count", 32'(count1), 32'd1);
        @(posedge clk); #1;
        chk("fwft_hold", 32'(dout1), 32'h5C);
        re1 = 1'b1;
        @(posedge clk); #1;
        re1 = 1'b0;
        chk("fwft_pop_empty", 32'(empty1), 32'd1);
        chk("fwft_pop_dout", 32'(dout1), 32'd0);
        chk("fwft_pop_valid", 32'(dout_valid1), 32'd0);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
        we1 = 1'b1; din1 = 8'h99;
        @(posedge clk); #1;
        we1 = 1'b0;
        we = 1'b1; din = 8'h77; re = 1'b1;
        @(posedge clk); #1;
        chk("mid_count", 32'(count), 32'd9);
        chk("mid_dout_valid", 32'(dout_valid), 32'd1);
        chk("mid_dout", 32'(dout), 32'h30);
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_almost_empty", 32'(almost_empty), 32'd1);
        chk("arst_almost_full", 32'(almost_full), 32'd0);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_dout_valid", 32'(dout_valid), 32'd0);
        chk("arst_fwft_dout", 32'(dout1), 32'd0);
        chk("arst_fwft_empty", 32'(empty1), 32'd1);
        we = 1'b0; re = 1'b0;
        model.delete();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk_status(1'b0, 1'b0);
        cyc(1'b1, 8'hE1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("post_rst_dout", 32'(dout), 32'hE1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
